pipelined_regfile_scoreboard: RTL

Parametrised register file with read-side write-back bypass and a per-register pending-write scoreboard for the pipelined core. Decode presents up to two source registers and one destination. The block returns operand data, stalls decode on RAW hazards and on pending-counter saturation, and commits write-back results. It replaces the purely combinational register-file steering. Register storage and hazard tracking live inside the block.

---
 rtl/pipelined_regfile_scoreboard.sv | 119 +++++++++++
 1 files changed

// File: rtl/pipelined_regfile_scoreboard.sv
// Register file with same-cycle write-back bypass on both read ports and a
// per-register pending-write counter that stalls decode on RAW hazards.
`timescale 1ns/1ps
module pipelined_regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int PEND_WIDTH = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dec_valid,
    output logic                  dec_ready,
    input  logic [ADDR_WIDTH-1:0] dec_rs0,
    input  logic                  dec_rs0_en,
    input  logic [ADDR_WIDTH-1:0] dec_rs1,
    input  logic                  dec_rs1_en,
    input  logic [ADDR_WIDTH-1:0] dec_rd,
    input  logic                  dec_rd_en,
    output logic [DATA_WIDTH-1:0] rd_data0,
    output logic [DATA_WIDTH-1:0] rd_data1,
    input  logic                  wb_we,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  flush,
    output logic                  sb_err
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;
    localparam logic [PEND_WIDTH-1:0] PEND_ONE = PEND_WIDTH'(1);

    // Register 0 is hard-wired to zero and never scoreboarded when ZERO_REG is set.
    function automatic logic tracked(input logic [ADDR_WIDTH-1:0] a);
        return !(ZERO_REG == 1 && a == '0);
    endfunction

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [PEND_WIDTH-1:0] pend_q [NUM_REGS];
    logic [PEND_WIDTH-1:0] pend_d [NUM_REGS];
    logic                  sb_err_q;
    logic                  sb_err_d;

    logic [NUM_REGS-1:0]   inc_vec;
    logic [NUM_REGS-1:0]   dec_vec;
    logic [NUM_REGS-1:0]   pend_zero_vec;

    logic hazard0;
    logic hazard1;
    logic sat;
    logic issue;
    logic wb_hit0;
    logic wb_hit1;
    logic wb_hit_rd;

    assign wb_hit0   = wb_we && (wb_addr == dec_rs0);
    assign wb_hit1   = wb_we && (wb_addr == dec_rs1);
    assign wb_hit_rd = wb_we && (wb_addr == dec_rd);

    always_comb begin
        rd_data0 = wb_hit0 ? wb_data : regs_q[dec_rs0];
        rd_data1 = wb_hit1 ? wb_data : regs_q[dec_rs1];
        if (!tracked(dec_rs0)) rd_data0 = '0;
        if (!tracked(dec_rs1)) rd_data1 = '0;
    end

    // A lone outstanding write landing this cycle is covered by the bypass.
    assign hazard0 = dec_rs0_en && tracked(dec_rs0) && (pend_q[dec_rs0] != '0)
                     && !(wb_hit0 && pend_q[dec_rs0] == PEND_ONE);
    assign hazard1 = dec_rs1_en && tracked(dec_rs1) && (pend_q[dec_rs1] != '0)
                     && !(wb_hit1 && pend_q[dec_rs1] == PEND_ONE);
    assign sat     = dec_rd_en && tracked(dec_rd) && (pend_q[dec_rd] == PEND_MAX) && !wb_hit_rd;

    assign dec_ready = !(hazard0 || hazard1 || sat || flush);
    assign issue     = dec_valid && dec_ready;
    assign sb_err    = sb_err_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            localparam logic [ADDR_WIDTH-1:0] IDX = ADDR_WIDTH'(gi);
            assign inc_vec[gi]       = issue && dec_rd_en && (dec_rd == IDX) && tracked(IDX);
            assign dec_vec[gi]       = wb_we && (wb_addr == IDX) && tracked(IDX);
            assign pend_zero_vec[gi] = (pend_q[gi] == '0);
        end
    endgenerate

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            pend_d[r] = pend_q[r];
            if (flush) begin
                pend_d[r] = '0;
            end else if (inc_vec[r] && !dec_vec[r]) begin
                pend_d[r] = pend_q[r] + PEND_ONE;
            end else if (dec_vec[r] && !inc_vec[r] && !pend_zero_vec[r]) begin
                pend_d[r] = pend_q[r] - PEND_ONE;
            end
        end
        // Write-back without a matching in-flight writer is a scoreboard error.
        sb_err_d = sb_err_q || (|(dec_vec & ~inc_vec & pend_zero_vec));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
                pend_q[r] <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (dec_vec[r]) regs_q[r] <= wb_data;
                pend_q[r] <= pend_d[r];
            end
            sb_err_q <= sb_err_d;
        end
    end

endmodule
